// File: rtl/common_pkg.sv
// rtl/common_pkg.sv - shared credit sizing helpers for Fifo feeder and Fifo-side credit logic
package common_pkg;

   // Wide enough to hold the value depth itself, not just 0..depth-1.
   function automatic int credit_width(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/credit_counter.sv
// rtl/credit_counter.sv - saturating free-slot counter, resets to p_max
module credit_counter
   import common_pkg::*;
#(
   parameter int p_max = 32
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          dec,
   input  logic                          inc,
   output logic [credit_width(p_max)-1:0] count,
   output logic                          nonzero,
   output logic                          full,
   output logic                          ovf
);

   localparam int cw = credit_width(p_max);
   localparam logic [cw-1:0] max_count = cw'(p_max);

   // Simultaneous dec and inc cancel; inc at max saturates instead of wrapping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= max_count;
      end else if (dec && !inc) begin
         count <= count - cw'(1);
      end else if (inc && !dec && !full) begin
         count <= count + cw'(1);
      end
   end

   assign nonzero = (count != '0);
   assign full    = (count == max_count);
   assign ovf     = inc && !dec && full;

endmodule

// File: rtl/fifo_credit_sender.sv
// rtl/fifo_credit_sender.sv - val/rdy to registered push/wdata feeder with credit flow control
module fifo_credit_sender
   import common_pkg::*;
#(
   parameter type t_entry   = logic [31:0],
   parameter int  p_credits = 32
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              istream_val,
   output logic                              istream_rdy,
   input  t_entry                            istream_msg,
   output logic                              push,
   output t_entry                            wdata,
   input  logic                              credit_return,
   output logic [credit_width(p_credits)-1:0] credits,
   output logic                              idle,
   output logic                              overflow_err
);

   logic fire;
   logic nonzero;
   logic full;
   logic ovf;

   generate
      if (p_credits < 2) begin : g_bad_depth
         $error("fifo_credit_sender: p_credits must be >= 2");
      end
   endgenerate

   credit_counter #(
      .p_max (p_credits)
   ) u_credit_counter (
      .clk     (clk),
      .rst     (rst),
      .dec     (fire),
      .inc     (credit_return),
      .count   (credits),
      .nonzero (nonzero),
      .full    (full),
      .ovf     (ovf)
   );

   // rdy depends only on the counter state, never on same-cycle val or return.
   assign istream_rdy = nonzero;
   assign fire        = istream_val & nonzero;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         push  <= 1'b0;
         wdata <= '0;
      end else begin
         push <= fire;
         if (fire) begin
            wdata <= istream_msg;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         overflow_err <= 1'b0;
      end else if (ovf) begin
         overflow_err <= 1'b1;
      end
   end

   assign idle = full & ~push;

endmodule

// File: tb/tb_fifo_credit_sender.sv
// tb/tb_fifo_credit_sender.sv - directed and randomized checks of fifo_credit_sender with a depth-4 Fifo model
module tb_fifo_credit_sender;

   logic        clk;
   logic        rst;
   logic        istream_val;
   logic        istream_rdy;
   logic [31:0] istream_msg;
   logic        push;
   logic [31:0] wdata;
   logic        credit_return;
   logic [2:0]  credits;
   logic        idle;
   logic        overflow_err;

   int checks = 0;
   int errors = 0;

   fifo_credit_sender #(
      .t_entry   (logic [31:0]),
      .p_credits (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .istream_val   (istream_val),
      .istream_rdy   (istream_rdy),
      .istream_msg   (istream_msg),
      .push          (push),
      .wdata         (wdata),
      .credit_return (credit_return),
      .credits       (credits),
      .idle          (idle),
      .overflow_err  (overflow_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst = 1'b1;
      istream_val = 1'b0;
      istream_msg = '0;
      credit_return = 1'b0;
      #1;
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL reset_push got %0b exp 0", push); end
      checks++; if (wdata !== 32'h0) begin errors++; $display("FAIL reset_wdata got %h exp 0", wdata); end
      checks++; if (credits !== 3'd4) begin errors++; $display("FAIL reset_credits got %0d exp 4", credits); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %0b exp 1", idle); end
      checks++; if (istream_rdy !== 1'b1) begin errors++; $display("FAIL reset_rdy got %0b exp 1", istream_rdy); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL reset_ovf got %0b exp 0", overflow_err); end
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill();
      for (int i = 0; i < 4; i++) begin
         if (i > 0) begin
            checks++; if (push !== 1'b1) begin errors++; $display("FAIL fill_push[%0d] got %0b exp 1", i, push); end
            checks++; if (wdata !== 32'hA0 + 32'(i - 1)) begin errors++; $display("FAIL fill_wdata[%0d] got %h exp %h", i, wdata, 32'hA0 + 32'(i - 1)); end
         end
         checks++; if (credits !== 3'(4 - i)) begin errors++; $display("FAIL fill_credits[%0d] got %0d exp %0d", i, credits, 4 - i); end
         checks++; if (istream_rdy !== 1'b1) begin errors++; $display("FAIL fill_rdy[%0d] got %0b exp 1", i, istream_rdy); end
         istream_val = 1'b1;
         istream_msg = 32'hA0 + 32'(i);
         @(negedge clk);
      end
      checks++; if (push !== 1'b1) begin errors++; $display("FAIL fill_last_push got %0b exp 1", push); end
      checks++; if (wdata !== 32'hA3) begin errors++; $display("FAIL fill_last_wdata got %h exp a3", wdata); end
      checks++; if (credits !== 3'd0) begin errors++; $display("FAIL fill_empty_credits got %0d exp 0", credits); end
      checks++; if (istream_rdy !== 1'b0) begin errors++; $display("FAIL fill_rdy_low got %0b exp 0", istream_rdy); end
      istream_msg = 32'hFF;
      @(negedge clk);
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL stall_push got %0b exp 0", push); end
      checks++; if (wdata !== 32'hA3) begin errors++; $display("FAIL stall_wdata_hold got %h exp a3", wdata); end
      checks++; if (credits !== 3'd0) begin errors++; $display("FAIL stall_credits got %0d exp 0", credits); end
      istream_val = 1'b0;
   endtask

   task automatic test_credit_return();
      credit_return = 1'b1;
      @(negedge clk);
      credit_return = 1'b0;
      checks++; if (credits !== 3'd1) begin errors++; $display("FAIL ret_credits got %0d exp 1", credits); end
      checks++; if (istream_rdy !== 1'b1) begin errors++; $display("FAIL ret_rdy got %0b exp 1", istream_rdy); end
      istream_val = 1'b1;
      istream_msg = 32'hB0;
      @(negedge clk);
      istream_val = 1'b0;
      checks++; if (push !== 1'b1 || wdata !== 32'hB0) begin errors++; $display("FAIL ret_push got %0b/%h exp 1/b0", push, wdata); end
      checks++; if (credits !== 3'd0 || istream_rdy !== 1'b0) begin errors++; $display("FAIL ret_drain got %0d/%0b exp 0/0", credits, istream_rdy); end
   endtask

   task automatic test_back_to_back();
      credit_return = 1'b1;
      repeat (4) @(negedge clk);
      credit_return = 1'b0;
      checks++; if (credits !== 3'd4 || idle !== 1'b1) begin errors++; $display("FAIL b2b_refill got %0d/%0b exp 4/1", credits, idle); end
      for (int k = 0; k <= 100; k++) begin
         if (k > 0) begin
            checks++;
            if (push !== 1'b1 || wdata !== 32'hC000 + 32'(k - 1) || credits !== 3'd3 || istream_rdy !== 1'b1) begin
               errors++;
               $display("FAIL b2b[%0d] got push=%0b wdata=%h credits=%0d exp push=1 wdata=%h credits=3", k, push, wdata, credits, 32'hC000 + 32'(k - 1));
            end
         end
         istream_val = (k < 100);
         istream_msg = 32'hC000 + 32'(k);
         credit_return = (k > 0);
         @(negedge clk);
      end
      istream_val = 1'b0;
      credit_return = 1'b0;
      checks++; if (push !== 1'b0 || credits !== 3'd4 || idle !== 1'b1) begin errors++; $display("FAIL b2b_end got push=%0b credits=%0d idle=%0b exp 0/4/1", push, credits, idle); end
   endtask

   task automatic test_overflow();
      credit_return = 1'b1;
      @(negedge clk);
      credit_return = 1'b0;
      checks++; if (credits !== 3'd4) begin errors++; $display("FAIL ovf_saturate got %0d exp 4", credits); end
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_set got %0b exp 1", overflow_err); end
      istream_val = 1'b1;
      istream_msg = 32'hD0;
      @(negedge clk);
      istream_val = 1'b0;
      @(negedge clk);
      checks++; if (overflow_err !== 1'b1) begin errors++; $display("FAIL ovf_sticky got %0b exp 1", overflow_err); end
      checks++; if (credits !== 3'd3) begin errors++; $display("FAIL ovf_after_fire got %0d exp 3", credits); end
   endtask

   task automatic test_async_reset();
      istream_val = 1'b1;
      istream_msg = 32'hE0;
      @(negedge clk);
      istream_msg = 32'hE1;
      @(negedge clk);
      istream_val = 1'b0;
      checks++; if (credits !== 3'd1 || push !== 1'b1) begin errors++; $display("FAIL arst_pre got credits=%0d push=%0b exp 1/1", credits, push); end
      #2 rst = 1'b1;
      #1;
      checks++; if (push !== 1'b0) begin errors++; $display("FAIL arst_push got %0b exp 0", push); end
      checks++; if (credits !== 3'd4) begin errors++; $display("FAIL arst_credits got %0d exp 4", credits); end
      checks++; if (idle !== 1'b1) begin errors++; $display("FAIL arst_idle got %0b exp 1", idle); end
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL arst_ovf_clear got %0b exp 0", overflow_err); end
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      checks++; if (credits !== 3'd4 || push !== 1'b0 || wdata !== 32'h0) begin errors++; $display("FAIL arst_post got %0d/%0b/%h exp 4/0/0", credits, push, wdata); end
   endtask

   task automatic test_random_fifo();
      logic [31:0] acc[$];
      logic [31:0] fifo[$];
      logic [31:0] next_in;
      logic [31:0] next_out;
      logic [31:0] v;
      logic        pop;
      int          exp_credits;
      next_in = 32'h100;
      next_out = 32'h100;
      for (int c = 0; c < 400; c++) begin
         exp_credits = 4 - fifo.size() - int'(push);
         pop = (fifo.size() > 0) && ($urandom_range(0, 9) < 6);
         checks++; if (push === 1'b1 && fifo.size() == 4) begin errors++; $display("FAIL rnd_push_full cycle %0d got push into full Fifo", c); end
         checks++; if (int'(credits) != exp_credits) begin errors++; $display("FAIL rnd_credits cycle %0d got %0d exp %0d", c, credits, exp_credits); end
         if (pop) begin
            v = fifo.pop_front();
            checks++; if (v !== next_out) begin errors++; $display("FAIL rnd_order cycle %0d got %h exp %h", c, v, next_out); end
            next_out++;
         end
         if (push === 1'b1) begin
            if (acc.size() == 0) begin
               errors++; checks++;
               $display("FAIL rnd_spurious_push cycle %0d got %h exp none", c, wdata);
            end else begin
               v = acc.pop_front();
               checks++; if (wdata !== v) begin errors++; $display("FAIL rnd_wdata cycle %0d got %h exp %h", c, wdata, v); end
               fifo.push_back(wdata);
            end
         end
         credit_return = pop;
         istream_val = ($urandom_range(0, 9) < 7);
         istream_msg = next_in;
         if (istream_val && exp_credits != 0) begin
            acc.push_back(next_in);
            next_in++;
         end
         @(negedge clk);
      end
      istream_val = 1'b0;
      credit_return = 1'b0;
      checks++; if (overflow_err !== 1'b0) begin errors++; $display("FAIL rnd_no_ovf got %0b exp 0", overflow_err); end
      checks++; if (next_in - next_out < 32'd1 && next_in == 32'h100) begin errors++; $display("FAIL rnd_progress got %0d msgs exp >0", next_in - 32'h100); end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_credit_return();
      test_back_to_back();
      test_overflow();
      test_async_reset();
      test_random_fifo();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
